// File: rtl/data_io_tx.sv
// data_io_tx: SPI master that plays the IO-controller side of the data_io
// download protocol. It sends FILE_INDEX, FILE_INFO (DIRENTRY), FILE_TX start,
// the FILE_TX_DAT payload and FILE_TX end, taking payload bytes from a byte source.
//
// Source handshake: a byte moves when src_valid and src_ready are both high in
// the same cycle. src_ready is high for one cycle at a payload byte boundary,
// only while src_valid is high, and src_data is loaded into the shifter at that
// clock edge. If src_valid is low at a boundary, the bus stalls with SCK low and
// SS2 low until src_valid rises.
module data_io_tx #(
  parameter int          CLK_DIV       = 4,
  parameter int          GAP_CYCLES    = 8,
  parameter logic [7:0]  DIR_NAME_FILL = 8'h20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  index,
  input  logic [23:0] fileext,
  input  logic [31:0] filesize,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        SPI_SCK,
  output logic        SPI_SS2,
  output logic        SPI_DI,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEL    = 3'd1,
    S_BIT_LO = 3'd2,
    S_BIT_HI = 3'd3,
    S_DESEL  = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Frame selector values: index, info, tx start, payload, tx end.
  localparam logic [2:0] STEP_INDEX = 3'd0;
  localparam logic [2:0] STEP_INFO  = 3'd1;
  localparam logic [2:0] STEP_TXS   = 3'd2;
  localparam logic [2:0] STEP_DAT   = 3'd3;
  localparam logic [2:0] STEP_TXE   = 3'd4;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [5:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] remain_q, remain_d;
  logic        pend_q, pend_d;
  logic        aborted_q, aborted_d;
  logic [7:0]  idx_q, idx_d;
  logic [23:0] ext_q, ext_d;
  logic [31:0] size_q, size_d;

  logic [5:0]  nxt_idx;
  logic [5:0]  last_idx;
  logic [7:0]  frame_byte;

  // Index of the byte that would be loaded next in the current frame.
  assign nxt_idx  = (state_q == S_SEL) ? 6'd0 : byte_idx_q + 6'd1;
  assign last_idx = (step_q == STEP_INFO) ? 6'd32 : 6'd1;

  // Command/argument byte generator for all non-payload bytes.
  always_comb begin
    frame_byte = 8'h00;
    case (step_q)
      STEP_INDEX: frame_byte = (nxt_idx == 6'd0) ? 8'h55 : idx_q;
      STEP_INFO: begin
        if (nxt_idx == 6'd0)       frame_byte = 8'h56;
        else if (nxt_idx <= 6'd8)  frame_byte = DIR_NAME_FILL;
        else if (nxt_idx == 6'd9)  frame_byte = ext_q[23:16];
        else if (nxt_idx == 6'd10) frame_byte = ext_q[15:8];
        else if (nxt_idx == 6'd11) frame_byte = ext_q[7:0];
        else if (nxt_idx == 6'd29) frame_byte = size_q[7:0];
        else if (nxt_idx == 6'd30) frame_byte = size_q[15:8];
        else if (nxt_idx == 6'd31) frame_byte = size_q[23:16];
        else if (nxt_idx == 6'd32) frame_byte = size_q[31:24];
        else                       frame_byte = 8'h00;
      end
      STEP_TXS:   frame_byte = (nxt_idx == 6'd0) ? 8'h53 : 8'hFF;
      STEP_DAT:   frame_byte = 8'h54;
      default:    frame_byte = (nxt_idx == 6'd0) ? 8'h53 : 8'h00;
    endcase
  end

  // Next-state logic: frame sequencing, bit timing and payload handshake.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    remain_d   = remain_q;
    pend_d     = pend_q;
    aborted_d  = aborted_q;
    idx_d      = idx_q;
    ext_d      = ext_q;
    size_d     = size_q;
    src_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d     = index;
          ext_d     = fileext;
          size_d    = filesize;
          remain_d  = filesize;
          aborted_d = 1'b0;
          step_d    = STEP_INDEX;
          cnt_d     = 16'd0;
          pend_d    = 1'b0;
          state_d   = S_SEL;
        end
      end
      S_SEL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = 16'd0;
          byte_idx_d = 6'd0;
          bit_cnt_d  = 3'd0;
          shift_d    = frame_byte;
          state_d    = S_BIT_LO;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BIT_LO: begin
        if (pend_q) begin
          // Stalled at a payload byte boundary: SCK stays low until data arrives.
          if (abort && remain_q != 32'd0) begin
            aborted_d = 1'b1;
            pend_d    = 1'b0;
            cnt_d     = 16'd0;
            state_d   = S_DESEL;
          end else if (src_valid) begin
            src_ready = 1'b1;
            shift_d   = src_data;
            remain_d  = remain_q - 32'd1;
            pend_d    = 1'b0;
            cnt_d     = 16'd0;
          end
        end else if (cnt_q == DIV_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_BIT_HI;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BIT_HI: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = 16'd0;
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            state_d   = S_BIT_LO;
          end else begin
            bit_cnt_d  = 3'd0;
            byte_idx_d = nxt_idx;
            if (step_q == STEP_DAT) begin
              if (remain_q == 32'd0) begin
                state_d = S_DESEL;
              end else if (abort) begin
                aborted_d = 1'b1;
                state_d   = S_DESEL;
              end else if (src_valid) begin
                src_ready = 1'b1;
                shift_d   = src_data;
                remain_d  = remain_q - 32'd1;
                state_d   = S_BIT_LO;
              end else begin
                pend_d  = 1'b1;
                state_d = S_BIT_LO;
              end
            end else if (byte_idx_q == last_idx) begin
              state_d = S_DESEL;
            end else begin
              shift_d = frame_byte;
              state_d = S_BIT_LO;
            end
          end
        end
      end
      S_DESEL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 16'd0;
          if (step_q == STEP_TXE) begin
            state_d = S_DONE;
          end else begin
            // An empty file has no payload frame.
            step_d  = (step_q == STEP_TXS && size_q == 32'd0) ? STEP_TXE : step_q + 3'd1;
            state_d = S_SEL;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops SS2 at once and discards any partial frame.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= STEP_INDEX;
      byte_idx_q <= 6'd0;
      bit_cnt_q  <= 3'd0;
      cnt_q      <= 16'd0;
      shift_q    <= 8'h00;
      remain_q   <= 32'd0;
      pend_q     <= 1'b0;
      aborted_q  <= 1'b0;
      idx_q      <= 8'h00;
      ext_q      <= 24'h0;
      size_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      remain_q   <= remain_d;
      pend_q     <= pend_d;
      aborted_q  <= aborted_d;
      idx_q      <= idx_d;
      ext_q      <= ext_d;
      size_q     <= size_d;
    end
  end

  assign SPI_SCK     = (state_q == S_BIT_HI);
  assign SPI_SS2     = !(state_q == S_SEL || state_q == S_BIT_LO ||
                         state_q == S_BIT_HI || state_q == S_DESEL);
  assign SPI_DI      = shift_q[7];
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign aborted     = aborted_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_data_io_tx.sv
// Directed bench for data_io_tx: decodes the SPI stream into frames and
// compares it against a hand-built frame list for each scenario.
module tb_data_io_tx;

  logic        clk;
  logic        reset, start, abort;
  logic [7:0]  index;
  logic [23:0] fileext;
  logic [31:0] filesize;
  logic [7:0]  src_data;
  logic        src_valid, src_ready;
  logic        SPI_SCK, SPI_SS2, SPI_DI;
  logic        busy, done, aborted;
  logic [2:0]  state_dbg;

  data_io_tx #(.CLK_DIV(2), .GAP_CYCLES(8), .DIR_NAME_FILL(8'h20)) dut (
    .clk_sys(clk), .reset(reset), .start(start), .abort(abort),
    .index(index), .fileext(fileext), .filesize(filesize),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .busy(busy), .done(done), .aborted(aborted), .state_dbg_o(state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected and decoded streams; 9'h100 marks an SS2 falling edge (frame start).
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] pay[0:15];

  int n_checks, n_fail;
  int src_idx, pay_n, stall_idx, stall_left, extra_start_at;
  bit abort_en;

  // SPI monitor state (written only by the monitor process).
  int         sck_rises = 0;
  int         di_viol   = 0;
  int         done_cnt  = 0;
  int         busy_cyc  = 0;
  int         mon_bits  = 0;
  logic       mon_sck_p = 1'b0;
  logic       mon_ss2_p = 1'b1;
  logic       mon_di_p  = 1'b0;
  logic [7:0] mon_sh    = 8'h00;

  always @(negedge clk) begin
    if (mon_ss2_p && !SPI_SS2) begin
      got_q.push_back(9'h100);
      mon_bits = 0;
    end
    if (!SPI_SS2 && SPI_SCK && !mon_sck_p) begin
      mon_sh = {mon_sh[6:0], SPI_DI};
      mon_bits++;
      sck_rises++;
      if (mon_bits == 8) begin
        got_q.push_back({1'b0, mon_sh});
        mon_bits = 0;
      end
    end
    if (SPI_SCK && (SPI_DI !== mon_di_p)) di_viol++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    mon_sck_p = SPI_SCK;
    mon_ss2_p = SPI_SS2;
    mon_di_p  = SPI_DI;
  end

  // Expected frame list for one complete transfer with npay payload bytes sent.
  task automatic build_exp(input logic [7:0] idx, input logic [23:0] ext,
                           input logic [31:0] size, input int npay);
    exp_q.delete();
    exp_q.push_back(9'h100); exp_q.push_back(9'h055); exp_q.push_back({1'b0, idx});
    exp_q.push_back(9'h100); exp_q.push_back(9'h056);
    for (int i = 0; i < 8; i++) exp_q.push_back(9'h020);
    exp_q.push_back({1'b0, ext[23:16]});
    exp_q.push_back({1'b0, ext[15:8]});
    exp_q.push_back({1'b0, ext[7:0]});
    for (int i = 0; i < 17; i++) exp_q.push_back(9'h000);
    exp_q.push_back({1'b0, size[7:0]});
    exp_q.push_back({1'b0, size[15:8]});
    exp_q.push_back({1'b0, size[23:16]});
    exp_q.push_back({1'b0, size[31:24]});
    exp_q.push_back(9'h100); exp_q.push_back(9'h053); exp_q.push_back(9'h0FF);
    if (size != 0) begin
      exp_q.push_back(9'h100); exp_q.push_back(9'h054);
      for (int i = 0; i < npay; i++) exp_q.push_back({1'b0, pay[i]});
    end
    exp_q.push_back(9'h100); exp_q.push_back(9'h053); exp_q.push_back(9'h000);
  endtask

  function automatic int stream_diff(input int base);
    int n;
    n = got_q.size() - base;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= n) return i;
      if (got_q[base + i] !== exp_q[i]) return i;
    end
    if (n != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic logic [8:0] got_at(input int base, input int i);
    if (i < 0 || base + i >= got_q.size()) return 9'h1FF;
    return got_q[base + i];
  endfunction

  function automatic logic [8:0] exp_at(input int i);
    if (i < 0 || i >= exp_q.size()) return 9'h1FF;
    return exp_q[i];
  endfunction

  task automatic src_update();
    if (src_idx == stall_idx && stall_left > 0) begin
      src_valid = 1'b0;
      stall_left--;
    end else begin
      src_valid = (src_idx < pay_n);
    end
    src_data = pay[src_idx < 16 ? src_idx : 15];
  endtask

  // Driver: present the start pulse with the given parameters.
  task automatic do_start(input logic [7:0] idx, input logic [23:0] ext, input logic [31:0] size);
    @(negedge clk);
    index = idx; fileext = ext; filesize = size;
    src_idx = 0;
    src_update();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Driver: run the byte source until done is seen at a negedge (bounded).
  task automatic run_xfer(input int max_cyc, output int rdy, output bit got_done);
    bit take;
    rdy = 0;
    got_done = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      take = src_ready && src_valid;
      if (take) rdy++;
      @(posedge clk); #1;
      start = 1'b0;
      if (c == extra_start_at) begin
        start = 1'b1;
        index = 8'hEE;
        filesize = 32'd99;
      end
      if (take) src_idx++;
      src_update();
      if (abort_en && src_idx >= 2) abort = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (SPI_SCK !== 1'b0)   begin n_fail++; $display("FAIL reset_sck: got %b want 0", SPI_SCK); end
    n_checks++; if (SPI_SS2 !== 1'b1)   begin n_fail++; $display("FAIL reset_ss2: got %b want 1", SPI_SS2); end
    n_checks++; if (SPI_DI !== 1'b0)    begin n_fail++; $display("FAIL reset_di: got %b want 0", SPI_DI); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready: got %b want 0", src_ready); end
    n_checks++; if (aborted !== 1'b0)   begin n_fail++; $display("FAIL reset_aborted: got %b want 0", aborted); end
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_basic();
    int b_got, b_sck, b_viol, b_done, b_busy, rdy, pos;
    bit ok;
    pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'h00; pay[3] = 8'hFF;
    pay_n = 4; stall_left = 0;
    build_exp(8'h03, 24'h524F4D, 32'd4, 4);
    b_got = got_q.size(); b_sck = sck_rises; b_viol = di_viol; b_done = done_cnt; b_busy = busy_cyc;
    do_start(8'h03, 24'h524F4D, 32'd4);
    run_xfer(5000, rdy, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done_timeout: got %b want 1", ok); end
    // start presented in the done cycle must be ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_start_in_done: busy got %b want 0", busy); end
    @(negedge clk);
    pos = stream_diff(b_got);
    n_checks++; if (pos !== -1) begin n_fail++; $display("FAIL basic_stream: at %0d got %h want %h", pos, got_at(b_got, pos), exp_at(pos)); end
    n_checks++; if (rdy !== 4) begin n_fail++; $display("FAIL basic_src_ready: got %0d want 4", rdy); end
    n_checks++; if (done_cnt - b_done !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - b_done); end
    n_checks++; if (busy_cyc - b_busy !== 1468) begin n_fail++; $display("FAIL basic_cycles: got %0d want 1468", busy_cyc - b_busy); end
    n_checks++; if (sck_rises - b_sck !== 352) begin n_fail++; $display("FAIL basic_sck_edges: got %0d want 352", sck_rises - b_sck); end
    n_checks++; if (di_viol - b_viol !== 0) begin n_fail++; $display("FAIL basic_di_stable: got %0d want 0", di_viol - b_viol); end
    n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL basic_aborted: got %b want 0", aborted); end
  endtask

  task automatic test_zero_size();
    int b_got, b_busy, rdy, pos;
    bit ok;
    pay_n = 0; stall_left = 0;
    build_exp(8'h07, 24'h424953, 32'd0, 0);
    b_got = got_q.size(); b_busy = busy_cyc;
    do_start(8'h07, 24'h424953, 32'd0);
    run_xfer(5000, rdy, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_done_timeout: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    pos = stream_diff(b_got);
    n_checks++; if (pos !== -1) begin n_fail++; $display("FAIL zero_stream: at %0d got %h want %h", pos, got_at(b_got, pos), exp_at(pos)); end
    n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL zero_src_ready: got %0d want 0", rdy); end
    n_checks++; if (busy_cyc - b_busy !== 1296) begin n_fail++; $display("FAIL zero_cycles: got %0d want 1296", busy_cyc - b_busy); end
  endtask

  task automatic test_abort();
    int b_got, b_busy, rdy, pos;
    bit ok;
    for (int i = 0; i < 10; i++) pay[i] = 8'h10 + 8'(i);
    pay_n = 10; stall_left = 0; abort_en = 1'b1;
    build_exp(8'h03, 24'h524F4D, 32'd10, 2);
    b_got = got_q.size(); b_busy = busy_cyc;
    do_start(8'h03, 24'h524F4D, 32'd10);
    run_xfer(5000, rdy, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_done_timeout: got %b want 1", ok); end
    n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b want 1", aborted); end
    abort = 1'b0; abort_en = 1'b0;
    repeat (2) @(negedge clk);
    pos = stream_diff(b_got);
    n_checks++; if (pos !== -1) begin n_fail++; $display("FAIL abort_stream: at %0d got %h want %h", pos, got_at(b_got, pos), exp_at(pos)); end
    n_checks++; if (rdy !== 2) begin n_fail++; $display("FAIL abort_src_ready: got %0d want 2", rdy); end
    n_checks++; if (busy_cyc - b_busy !== 1404) begin n_fail++; $display("FAIL abort_cycles: got %0d want 1404", busy_cyc - b_busy); end
  endtask

  task automatic test_stall();
    int b_got, b_sck, b_viol, b_busy, rdy, pos;
    bit ok;
    pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'h00; pay[3] = 8'hFF;
    pay_n = 4; stall_idx = 2; stall_left = 50;
    build_exp(8'h03, 24'h524F4D, 32'd4, 4);
    b_got = got_q.size(); b_sck = sck_rises; b_viol = di_viol; b_busy = busy_cyc;
    do_start(8'h03, 24'h524F4D, 32'd4);
    @(negedge clk);
    n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL stall_aborted_cleared: got %b want 0", aborted); end
    run_xfer(5000, rdy, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_done_timeout: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    pos = stream_diff(b_got);
    n_checks++; if (pos !== -1) begin n_fail++; $display("FAIL stall_stream: at %0d got %h want %h", pos, got_at(b_got, pos), exp_at(pos)); end
    n_checks++; if (rdy !== 4) begin n_fail++; $display("FAIL stall_src_ready: got %0d want 4", rdy); end
    n_checks++; if (busy_cyc - b_busy !== 1487) begin n_fail++; $display("FAIL stall_cycles: got %0d want 1487", busy_cyc - b_busy); end
    n_checks++; if (sck_rises - b_sck !== 352) begin n_fail++; $display("FAIL stall_sck_edges: got %0d want 352", sck_rises - b_sck); end
    n_checks++; if (di_viol - b_viol !== 0) begin n_fail++; $display("FAIL stall_di_stable: got %0d want 0", di_viol - b_viol); end
    stall_idx = -1; stall_left = 0;
  endtask

  task automatic test_reset_mid();
    int b_got, b_busy, rdy, pos;
    bit ok;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    pay_n = 3;
    do_start(8'h03, 24'h524F4D, 32'd3);
    repeat (200) @(negedge clk);
    n_checks++; if (state_dbg === 3'd0 || SPI_SS2 !== 1'b0) begin n_fail++; $display("FAIL midreset_in_frame: state %0d ss2 %b want active frame", state_dbg, SPI_SS2); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (SPI_SS2 !== 1'b1) begin n_fail++; $display("FAIL midreset_ss2: got %b want 1", SPI_SS2); end
    n_checks++; if (SPI_SCK !== 1'b0) begin n_fail++; $display("FAIL midreset_sck: got %b want 0", SPI_SCK); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    build_exp(8'h03, 24'h524F4D, 32'd3, 3);
    b_got = got_q.size(); b_busy = busy_cyc;
    extra_start_at = 300;
    do_start(8'h03, 24'h524F4D, 32'd3);
    run_xfer(5000, rdy, ok);
    extra_start_at = -1;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL restart_done_timeout: got %b want 1", ok); end
    repeat (2) @(negedge clk);
    pos = stream_diff(b_got);
    n_checks++; if (pos !== -1) begin n_fail++; $display("FAIL restart_stream: at %0d got %h want %h", pos, got_at(b_got, pos), exp_at(pos)); end
    n_checks++; if (rdy !== 3) begin n_fail++; $display("FAIL restart_src_ready: got %0d want 3", rdy); end
    n_checks++; if (busy_cyc - b_busy !== 1436) begin n_fail++; $display("FAIL restart_cycles: got %0d want 1436", busy_cyc - b_busy); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    index = 8'h00; fileext = 24'h0; filesize = 32'd0;
    src_data = 8'h00; src_valid = 1'b0;
    for (int i = 0; i < 16; i++) pay[i] = 8'h00;
    src_idx = 0; pay_n = 0; stall_idx = -1; stall_left = 0;
    extra_start_at = -1; abort_en = 1'b0;
    n_checks = 0; n_fail = 0;
    test_reset();
    test_basic();
    test_zero_size();
    test_abort();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_io_tx.md
Name: data_io_tx

Overview:
- Hardware SPI master that drives the data_io download protocol from the IO-controller side: FILE_INDEX, FILE_INFO, FILE_TX start, FILE_TX_DAT payload, FILE_TX end.
- Streams bytes from a ready/valid byte source, such as a boot ROM or flash reader, onto SPI_SCK/SPI_SS2/SPI_DI.
- Used for stand-alone boot and for loopback verification against the data_io receiver.

Parameters:
- CLK_DIV, 4: clk_sys cycles per SCK half-period. Legal range 2..255.
- GAP_CYCLES, 8: clk_sys cycles SS2 is held high between frames. Minimum 1.
- DIR_NAME_FILL, 8'h20: fill byte for DIRENTRY name bytes 0..7.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches index/fileext/filesize and begins a transfer; ignored while busy
- abort  in  1  level; ends the payload early (see Behaviour)
- index  in  8  menu index sent in FILE_INDEX
- fileext  in  24  extension; [23:16] is sent first
- filesize  in  32  payload byte count
- src_data  in  8  payload byte
- src_valid  in  1  src_data valid
- src_ready  out  1  one-cycle pulse when src_data is loaded into the shifter
- SPI_SCK  out  1  SPI clock, idle low (mode 0)
- SPI_SS2  out  1  data_io select, active low
- SPI_DI  out  1  MOSI
- busy  out  1  high from start accept to done
- done  out  1  one-cycle pulse after the final frame's gap
- aborted  out  1  sticky; set if abort truncated the payload; cleared on next start

Behaviour:
- Reset values: SPI_SCK=0, SPI_SS2=1, SPI_DI=0, busy=0, done=0, src_ready=0, aborted=0, FSM=IDLE. Reset mid-frame raises SS2 on the next edge; no partial frame resumes.
- Frame sequence, each frame = SS2 low, command byte, argument bytes, SS2 high, GAP_CYCLES idle:
  1. 0x55, index.
  2. 0x56, 32 bytes: 0..7=DIR_NAME_FILL; 8,9,10=fileext[23:16],[15:8],[7:0]; 11..27=0x00; 28..31=filesize little-endian ([7:0] first).
  3. 0x53, 0xFF.
  4. 0x54, payload bytes. This frame is omitted when filesize==0.
  5. 0x53, 0x00.
- FSM states: IDLE, SEL (SS2 low, wait CLK_DIV), BIT_LO (SCK low, DI valid), BIT_HI (SCK high), DESEL (SCK low, wait CLK_DIV, then SS2 high), GAP, DONE. A step counter selects frame 1..5.
- Bit timing: bits are MSB first. DI changes only while SCK is low, at least CLK_DIV cycles before the rising edge. Each bit is CLK_DIV low + CLK_DIV high. Byte = 16*CLK_DIV cycles.
- Bytes are back-to-back within a frame; there is no SCK gap unless stalled.
- Payload handshake: at each payload byte boundary (SCK low), if src_valid=1, load the shifter, pulse src_ready for 1 cycle, and start the bit. If src_valid=0, hold SCK low and SS2 low indefinitely (stall); DI holds its last value.
- A 32-bit down-counter holds bytes remaining. The frame ends when it reaches 0. src_ready pulses exactly filesize times.
- abort: sampled at payload byte boundaries only. When abort=1 and bytes remain, finish the current byte, close frame 4, set aborted, and continue with frame 5. Abort outside frame 4 has no effect.
- done pulses in the cycle after frame 5's GAP completes. busy falls in the same cycle. The FSM returns to IDLE.
- start in the done cycle is ignored; start is accepted from the following cycle.
- start while busy is ignored; latched parameters are stable for the whole transfer.
- Cycle counts (no stall, CLK_DIV=D, G=GAP_CYCLES): frame with n total bytes = D + 16*D*n + D + G.

Test Plan:
- CLK_DIV=2, GAP=8, index=0x03, ext="ROM", filesize=4, source always valid with bytes A5,5A,00,FF -> SPI monitor decodes frames [55 03], [56 20x8 52 4F 4D 00x17 04 00 00 00], [53 FF], [54 A5 5A 00 FF], [53 00]. src_ready pulses 4 times. done pulses once; total cycles match the formula.
- Loopback into the data_io receiver, clkref_n=0, filesize=16 -> ioctl_download rises, ioctl_wr pulses 16 times at addresses 0..15 with matching data, ioctl_fileext=0x524F4D, ioctl_filesize=16, ioctl_index=0x03.
- filesize=0 -> frames 0x55, 0x56, 0x53 FF, 0x53 00 only; src_ready never pulses.
- src_valid dropped for 50 cycles before payload byte 2 -> SCK low and SS2 low for the stall, no extra edges, decoded data still correct.
- abort asserted during payload byte 1 of 10 -> byte 1 completes, frame 4 ends after 2 payload bytes, frame [53 00] follows, aborted=1, done pulses.
- reset asserted mid-INFO frame -> next cycle SS2=1, SCK=0, busy=0. A new start produces a complete, correct sequence. start pulsed while busy -> no effect on the frame stream.
